// File: rtl/geo_xform_unit.sv
// geo_xform_unit: creates, deletes and transforms (translate/scale/rotate/reflect) stored objects.
// Define GEO_SATURATE_EN to clamp add, shift-left and negate results instead of wrapping.
module geo_xform_unit #(
  parameter int COORD_W = 16,
  parameter int NUM_VERTS = 4,
  parameter int IDX_W = 5,
  localparam int VW = 2*NUM_VERTS*COORD_W,
  localparam int OBJ_W = VW + 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic [2:0]          op,
  input  logic [2:0]          code,
  input  logic [IDX_W-1:0]    obj_num_in,
  input  logic [1:0]          obj_type,
  input  logic [7:0]          obj_color,
  input  logic [VW-1:0]       vin,
  input  logic [COORD_W-1:0]  dx,
  input  logic [COORD_W-1:0]  dy,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IDX_W-1:0]    lst_stored_obj,
  output logic                crt_obj,
  output logic                del_obj,
  output logic                del_all,
  output logic [IDX_W-1:0]    obj_num_out,
  input  logic                addr_vld,
  input  logic [IDX_W-1:0]    alloc_idx,
  input  logic                obj_mem_full,
  output logic                mem_rd_en,
  output logic                mem_wr_en,
  output logic [IDX_W-1:0]    mem_addr,
  output logic [OBJ_W-1:0]    mem_wr_data,
  input  logic [OBJ_W-1:0]    mem_rd_data,
  input  logic                mem_rd_vld
);
  localparam int KW = $clog2(NUM_VERTS);
  typedef logic signed [COORD_W-1:0] crd_t;
  typedef enum logic [2:0] {IDLE, ALLOC, READ, WAIT_RD, XFORM, WRITE, DONE, DEL} state_t;
`ifdef GEO_SATURATE_EN
  localparam logic [COORD_W-1:0] SMAX = {1'b0, {(COORD_W-1){1'b1}}};
  localparam logic [COORD_W-1:0] SMIN = {1'b1, {(COORD_W-1){1'b0}}};
`endif

  function automatic crd_t add_c(input crd_t a, input crd_t b);
`ifdef GEO_SATURATE_EN
    logic [COORD_W:0] s;
    s = {a[COORD_W-1], a} + {b[COORD_W-1], b};
    return (s[COORD_W] != s[COORD_W-1]) ? (s[COORD_W] ? SMIN : SMAX) : s[COORD_W-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic crd_t neg_c(input crd_t a);
`ifdef GEO_SATURATE_EN
    return (a == SMIN) ? SMAX : -a;
`else
    return -a;
`endif
  endfunction

  function automatic crd_t shl_c(input crd_t a, input logic [1:0] s);
`ifdef GEO_SATURATE_EN
    logic [COORD_W+3:0] w;
    w = {{4{a[COORD_W-1]}}, a} << s;
    return (w[COORD_W+3:COORD_W-1] != {5{w[COORD_W+3]}}) ? (w[COORD_W+3] ? SMIN : SMAX) : w[COORD_W-1:0];
`else
    return a <<< s;
`endif
  endfunction

  state_t          state;
  logic [2:0]      op_r, code_r;
  crd_t            dx_r, dy_r;
  logic [KW-1:0]   k;
  logic [OBJ_W-1:0] obj, obj_nx;
  crd_t            x, y, nx, ny;
  int              base;

  // Vertex k of the buffered word, transformed; vertices beyond the stored count pass through.
  always_comb begin
    base = int'(k) * 2 * COORD_W;
    x = obj[base +: COORD_W];
    y = obj[base + COORD_W +: COORD_W];
    nx = x;
    ny = y;
    case (op_r)
      3'd2: begin nx = add_c(x, dx_r); ny = add_c(y, dy_r); end
      3'd3: begin
        nx = code_r[2] ? x >>> code_r[1:0] : shl_c(x, code_r[1:0]);
        ny = code_r[2] ? y >>> code_r[1:0] : shl_c(y, code_r[1:0]);
      end
      3'd4: begin nx = neg_c(y); ny = x; end
      3'd5: begin nx = y; ny = neg_c(x); end
      3'd6: begin nx = code_r[0] ? neg_c(x) : x; ny = code_r[0] ? y : neg_c(y); end
      default: ;
    endcase
    obj_nx = obj;
    if (int'(k) <= int'(obj[VW+8 +: 2])) begin
      obj_nx[base +: COORD_W] = nx;
      obj_nx[base + COORD_W +: COORD_W] = ny;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      lst_stored_obj <= '0;
      crt_obj <= 1'b0;
      del_obj <= 1'b0;
      del_all <= 1'b0;
      obj_num_out <= '0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr <= '0;
      mem_wr_data <= '0;
      op_r <= '0;
      code_r <= '0;
      dx_r <= '0;
      dy_r <= '0;
      k <= '0;
      obj <= '0;
    end else begin
      crt_obj <= 1'b0;
      del_obj <= 1'b0;
      del_all <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (go) begin
          busy <= 1'b1;
          op_r <= op;
          code_r <= code;
          dx_r <= dx;
          dy_r <= dy;
          mem_addr <= obj_num_in;
          obj <= {6'b0, obj_type, obj_color, vin};
          if (op == 3'd0 && !obj_mem_full) begin
            crt_obj <= 1'b1;
            state <= ALLOC;
          end else if (op == 3'd0 || op == 3'd7) begin
            done <= 1'b1;
            err <= 1'b1;
            state <= DONE;
          end else if (op == 3'd1) begin
            del_obj <= 1'b1;
            del_all <= code[0];
            obj_num_out <= obj_num_in;
            state <= DEL;
          end else begin
            mem_rd_en <= 1'b1;
            state <= READ;
          end
        end
        ALLOC: if (addr_vld) begin
          lst_stored_obj <= alloc_idx;
          mem_addr <= alloc_idx;
          mem_wr_data <= obj;
          mem_wr_en <= 1'b1;
          state <= WRITE;
        end
        READ: state <= WAIT_RD;
        WAIT_RD: if (mem_rd_vld) begin
          obj <= mem_rd_data;
          k <= '0;
          state <= XFORM;
        end
        XFORM: begin
          obj <= obj_nx;
          k <= k + 1'b1;
          if (k == KW'(NUM_VERTS-1)) begin
            mem_wr_data <= obj_nx;
            mem_wr_en <= 1'b1;
            state <= WRITE;
          end
        end
        WRITE, DEL: begin
          done <= 1'b1;
          state <= DONE;
        end
        default: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_geo_xform_unit.sv
// tb_geo_xform_unit: scoreboarded bench for geo_xform_unit; follows GEO_SATURATE_EN like the design.
module tb_geo_xform_unit;
  localparam int CW = 16, NV = 4, IW = 5, OW = 2*NV*CW + 16;
`ifdef GEO_SATURATE_EN
  localparam logic [15:0] SC_EXP = 16'h7fff, NG_EXP = 16'h7fff;
`else
  localparam logic [15:0] SC_EXP = 16'hfffe, NG_EXP = 16'h8000;
`endif

  logic clk = 1'b0, rst_n;
  logic go, busy, done, err, crt_obj, del_obj, del_all, addr_vld, obj_mem_full;
  logic mem_rd_en, mem_wr_en, mem_rd_vld;
  logic [2:0] op, code;
  logic [IW-1:0] obj_num_in, lst_stored_obj, obj_num_out, alloc_idx, mem_addr;
  logic [1:0] obj_type;
  logic [7:0] obj_color;
  logic [OW-17:0] vin;
  logic [CW-1:0] dx, dy;
  logic [OW-1:0] mem_wr_data, mem_rd_data;

  typedef struct packed {logic [IW-1:0] a; logic [OW-1:0] d;} wr_t;
  wr_t exp_q[$];
  logic [OW-1:0] mem [32];
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  geo_xform_unit #(.COORD_W(CW), .NUM_VERTS(NV), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .op(op), .code(code), .obj_num_in(obj_num_in),
    .obj_type(obj_type), .obj_color(obj_color), .vin(vin), .dx(dx), .dy(dy),
    .busy(busy), .done(done), .err(err), .lst_stored_obj(lst_stored_obj),
    .crt_obj(crt_obj), .del_obj(del_obj), .del_all(del_all), .obj_num_out(obj_num_out),
    .addr_vld(addr_vld), .alloc_idx(alloc_idx), .obj_mem_full(obj_mem_full),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_rd_vld(mem_rd_vld));

  function automatic logic [OW-1:0] mkobj(input logic [7:0] t, col, input int x0, y0, x1, y1, x2, y2, x3, y3);
    return {t, col, 16'(y3), 16'(x3), 16'(y2), 16'(x2), 16'(y1), 16'(x1), 16'(y0), 16'(x0)};
  endfunction

  function automatic logic [15:0] fix(input int v);
`ifdef GEO_SATURATE_EN
    return v > 32767 ? 16'h7fff : v < -32768 ? 16'h8000 : v[15:0];
`else
    return v[15:0];
`endif
  endfunction

  // Integer reference: compute exactly, then wrap or clamp to 16 bits.
  function automatic logic [OW-1:0] model(input logic [OW-1:0] w, input logic [2:0] o, c, input int ddx, ddy);
    logic [OW-1:0] r;
    logic signed [15:0] tx, ty;
    int x, y, nx, ny;
    r = w;
    for (int i = 0; i < NV; i++) begin
      if (i <= int'(w[OW-8 +: 2])) begin
        tx = w[32*i +: 16];
        ty = w[32*i+16 +: 16];
        x = tx;
        y = ty;
        nx = x;
        ny = y;
        case (o)
          3'd2: begin nx = x + ddx; ny = y + ddy; end
          3'd3: begin
            nx = c[2] ? x >>> c[1:0] : x * (1 << c[1:0]);
            ny = c[2] ? y >>> c[1:0] : y * (1 << c[1:0]);
          end
          3'd4: begin nx = -y; ny = x; end
          3'd5: begin nx = y; ny = -x; end
          3'd6: begin nx = c[0] ? -x : x; ny = c[0] ? y : -y; end
          default: ;
        endcase
        r[32*i +: 16] = fix(nx);
        r[32*i+16 +: 16] = fix(ny);
      end
    end
    return r;
  endfunction

  task automatic test_reset;
    total++; if ({busy, done, err, crt_obj, del_obj, del_all, mem_rd_en, mem_wr_en} !== 8'h00)
      $display("FAIL reset_strobes got %b exp 00000000", {busy, done, err, crt_obj, del_obj, del_all, mem_rd_en, mem_wr_en}); else passed++;
    total++; if ({lst_stored_obj, obj_num_out, mem_addr} !== '0)
      $display("FAIL reset_idx got %h exp 0", {lst_stored_obj, obj_num_out, mem_addr}); else passed++;
    total++; if (mem_wr_data !== '0) $display("FAIL reset_wdata got %h exp 0", mem_wr_data); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_create;
    logic [OW-1:0] w;
    int cyc, crt_n, crt_cyc, wcyc, dcyc;
    bit fin, derr;
    wr_t e;
    w = mkobj(8'h03, 8'hA5, 1, 2, 3, 4, 5, 6, 7, 8);
    exp_q.push_back('{a: 5'd9, d: w});
    {cyc, crt_n, crt_cyc, wcyc, dcyc, fin, derr} = '0;
    crt_cyc = -1; wcyc = -1; dcyc = -1;
    go = 1; op = 3'd0; obj_type = 2'd3; obj_color = 8'hA5; vin = w[OW-17:0]; alloc_idx = 5'd9; obj_num_in = 5'd2;
    for (int t = 0; t < 40 && !fin; t++) begin
      @(posedge clk); #1; cyc++;
      go = 0;
      addr_vld = (cyc == 3);
      if (crt_obj) begin crt_n++; crt_cyc = cyc; end
      if (mem_wr_en) begin
        wcyc = cyc; total++;
        if (exp_q.size() == 0) $display("FAIL create_wr got write exp none");
        else begin
          e = exp_q.pop_front();
          if (mem_addr !== e.a || mem_wr_data !== e.d) $display("FAIL create_wr got %0d:%h exp %0d:%h", mem_addr, mem_wr_data, e.a, e.d);
          else passed++;
        end
        mem[mem_addr] = mem_wr_data;
      end
      if (done) begin dcyc = cyc; derr = err; fin = 1; end
    end
    addr_vld = 0;
    total++; if (crt_n != 1 || crt_cyc != 1) $display("FAIL create_crt got n=%0d cyc=%0d exp n=1 cyc=1", crt_n, crt_cyc); else passed++;
    total++; if (wcyc != 4) $display("FAIL create_wr_cyc got %0d exp 4", wcyc); else passed++;
    total++; if (dcyc != 5 || derr) $display("FAIL create_done got cyc=%0d err=%0d exp cyc=5 err=0", dcyc, derr); else passed++;
    total++; if (lst_stored_obj !== 5'd9) $display("FAIL create_lst got %0d exp 9", lst_stored_obj); else passed++;
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_create_full;
    go = 1; op = 3'd0; obj_mem_full = 1;
    @(posedge clk); #1; go = 0;
    total++; if ({done, err, crt_obj} !== 3'b110) $display("FAIL full_c1 got %b exp 110", {done, err, crt_obj}); else passed++;
    @(posedge clk); #1; obj_mem_full = 0;
    total++; if ({done, err, busy, crt_obj} !== 4'b0) $display("FAIL full_c2 got %b exp 0000", {done, err, busy, crt_obj}); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_delete;
    go = 1; op = 3'd1; code = 3'b001; obj_num_in = 5'd7;
    @(posedge clk); #1; go = 0;
    total++; if ({del_obj, del_all, obj_num_out, done} !== {1'b1, 1'b1, 5'd7, 1'b0})
      $display("FAIL delete_c1 got %b exp 11001110", {del_obj, del_all, obj_num_out, done}); else passed++;
    @(posedge clk); #1;
    total++; if ({done, err, del_obj} !== 3'b100) $display("FAIL delete_c2 got %b exp 100", {done, err, del_obj}); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_op7;
    go = 1; op = 3'd7;
    @(posedge clk); #1; go = 0;
    total++; if ({done, err, mem_rd_en} !== 3'b110) $display("FAIL op7 got %b exp 110", {done, err, mem_rd_en}); else passed++;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_xform(input string nm, input logic [2:0] o, c, input logic [IW-1:0] idx, input int ddx, ddy, rd_lat, input bit poke);
    int cyc, rd_cyc, wcyc, dcyc, rd_at, dels;
    logic [IW-1:0] rd_addr;
    bit fin, derr;
    wr_t e;
    rd_cyc = -1; wcyc = -1; dcyc = -1; rd_at = 1 + rd_lat; dels = 0; fin = 0; derr = 0; rd_addr = '0; cyc = 0;
    exp_q.push_back('{a: idx, d: model(mem[idx], o, c, ddx, ddy)});
    go = 1; op = o; code = c; obj_num_in = idx; dx = 16'(ddx); dy = 16'(ddy);
    for (int t = 0; t < 40 && !fin; t++) begin
      @(posedge clk); #1; cyc++;
      go = poke && cyc == 2;
      op = go ? 3'd1 : o;
      mem_rd_vld = (cyc == rd_at);
      mem_rd_data = mem_rd_vld ? mem[idx] : '0;
      if (mem_rd_en) begin rd_cyc = cyc; rd_addr = mem_addr; end
      if (del_obj) dels++;
      if (mem_wr_en) begin
        wcyc = cyc; total++;
        if (exp_q.size() == 0) $display("FAIL %s_wr got write exp none", nm);
        else begin
          e = exp_q.pop_front();
          if (mem_addr !== e.a || mem_wr_data !== e.d) $display("FAIL %s_wr got %0d:%h exp %0d:%h", nm, mem_addr, mem_wr_data, e.a, e.d);
          else passed++;
        end
        mem[mem_addr] = mem_wr_data;
      end
      if (done) begin dcyc = cyc; derr = err; fin = 1; end
    end
    go = 0; mem_rd_vld = 0;
    total++; if (rd_cyc != 1 || rd_addr !== idx) $display("FAIL %s_rd got cyc=%0d addr=%0d exp cyc=1 addr=%0d", nm, rd_cyc, rd_addr, idx); else passed++;
    total++; if (wcyc != rd_at + NV + 1) $display("FAIL %s_wr_cyc got %0d exp %0d", nm, wcyc, rd_at + NV + 1); else passed++;
    total++; if (dcyc != wcyc + 1 || derr || dcyc < 0) $display("FAIL %s_done got cyc=%0d err=%0d exp cyc=%0d err=0", nm, dcyc, derr, wcyc + 1); else passed++;
    total++; if (dels != 0) $display("FAIL %s_busy_go got del_obj=%0d exp 0", nm, dels); else passed++;
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_transforms;
    logic [OW-1:0] o4;
    o4 = mkobj(8'h01, 8'h5C, 10, -5, 0, 0, 111, 222, -333, 444);
    mem[4] = o4;
    test_xform("translate", 3'd2, 3'd0, 5'd4, 3, -2, 1, 1'b0);
    total++; if (mem[4][63:0] !== {16'hFFFE, 16'd3, 16'hFFF9, 16'd13}) $display("FAIL translate_v01 got %h exp fffe0003fff9000d", mem[4][63:0]); else passed++;
    total++; if (mem[4][OW-1:64] !== o4[OW-1:64]) $display("FAIL translate_keep got %h exp %h", mem[4][OW-1:64], o4[OW-1:64]); else passed++;
    mem[6] = mkobj(8'h00, 8'h11, 100, -30, 5, 5, 5, 5, 5, 5);
    test_xform("rotl", 3'd4, 3'd0, 5'd6, 0, 0, 2, 1'b0);
    total++; if (mem[6][31:0] !== {16'd100, 16'd30}) $display("FAIL rotl_v0 got %h exp 0064001e", mem[6][31:0]); else passed++;
    mem[8] = mkobj(8'h00, 8'h22, -7, 9, 1, 1, 1, 1, 1, 1);
    test_xform("refl_y", 3'd6, 3'd1, 5'd8, 0, 0, 1, 1'b0);
    total++; if (mem[8][31:0] !== {16'd9, 16'd7}) $display("FAIL refl_y_v0 got %h exp 00090007", mem[8][31:0]); else passed++;
    mem[10] = mkobj(8'h00, 8'h33, 32767, 1, 0, 0, 0, 0, 0, 0);
    test_xform("scale_up", 3'd3, 3'd1, 5'd10, 0, 0, 1, 1'b0);
    total++; if (mem[10][15:0] !== SC_EXP) $display("FAIL scale_up_x got %h exp %h", mem[10][15:0], SC_EXP); else passed++;
    mem[11] = mkobj(8'h00, 8'h44, 5, -32768, 0, 0, 0, 0, 0, 0);
    test_xform("refl_x", 3'd6, 3'd0, 5'd11, 0, 0, 1, 1'b0);
    total++; if (mem[11][31:16] !== NG_EXP) $display("FAIL refl_x_y got %h exp %h", mem[11][31:16], NG_EXP); else passed++;
    mem[12] = mkobj(8'h03, 8'h55, -100, 37, 64, -1, -32768, 32767, 9, -9);
    test_xform("scale_dn", 3'd3, 3'b110, 5'd12, 0, 0, 2, 1'b0);
    test_xform("trans_sat", 3'd2, 3'd0, 5'd12, 32767, -32768, 1, 1'b0);
  endtask

  task automatic test_back_to_back;
    test_xform("rotr_busy", 3'd5, 3'd0, 5'd9, 0, 0, 3, 1'b1);
    test_xform("rotl_b2b", 3'd4, 3'd0, 5'd9, 0, 0, 1, 1'b0);
  endtask

  task automatic test_reset_mid;
    int wr_n, busy_n;
    wr_n = 0; busy_n = 0;
    go = 1; op = 3'd2; code = 3'd0; obj_num_in = 5'd4; dx = 16'd1; dy = 16'd1;
    @(posedge clk); #1; go = 0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) $display("FAIL rstmid_busy_pre got %b exp 1", busy); else passed++;
    #2 rst_n = 0;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      mem_rd_vld = 1; mem_rd_data = mem[4];
      if (busy) busy_n++;
      if (mem_wr_en || mem_rd_en || done) wr_n++;
    end
    mem_rd_vld = 0; rst_n = 1;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      if (busy) busy_n++;
      if (mem_wr_en || mem_rd_en || done) wr_n++;
    end
    total++; if (busy_n != 0) $display("FAIL rstmid_busy got %0d busy cycles exp 0", busy_n); else passed++;
    total++; if (wr_n != 0) $display("FAIL rstmid_strobes got %0d exp 0", wr_n); else passed++;
    test_xform("post_reset", 3'd2, 3'd0, 5'd4, -1, 1, 1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 0; go = 0; op = 0; code = 0; obj_num_in = 0; obj_type = 0; obj_color = 0; vin = '0;
    dx = 0; dy = 0; addr_vld = 0; alloc_idx = 0; obj_mem_full = 0; mem_rd_data = '0; mem_rd_vld = 0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_create;
    test_create_full;
    test_delete;
    test_op7;
    test_transforms;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/geo_xform_unit.md
# geo_xform_unit

Parametrised geometric command engine sitting between the CPU command interface, the object allocation unit and video object memory. It creates, deletes and transforms stored objects: translate, scale, rotate ±90°, and reflect. Transforms run as a read-modify-write of one object word, processing one vertex per cycle. Coordinate width and vertex count are parameters.

## Interface
- COORD_W, 16, signed coordinate width
- NUM_VERTS, 4, maximum vertices per object (power of two, ≥2)
- IDX_W, 5, object index width
- OBJ_W, derived = 2*NUM_VERTS*COORD_W+16; object word = {type[7:0], color[7:0], vertex pairs}; vertex i has x at [2i*COORD_W +: COORD_W] and y at the next COORD_W bits
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- go  in  1  command strobe; accepted only in IDLE
- op  in  3  0 create, 1 delete, 2 translate, 3 scale, 4 rot left, 5 rot right, 6 reflect, 7 reserved
- code  in  3  scale: [1:0] shift amount, [2] 1 = shrink; reflect: [0] 1 = about y-axis; delete: [0] 1 = all
- obj_num_in  in  IDX_W  target object
- obj_type  in  2  create: vertex count minus 1
- obj_color  in  8  create colour
- vin  in  2*NUM_VERTS*COORD_W  create vertices
- dx, dy  in  COORD_W  translate offsets
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, with done, on failure
- lst_stored_obj  out  IDX_W  index allocated by the last successful create
- crt_obj, del_obj  out  1  one-cycle requests to the object unit
- del_all  out  1  qualifies del_obj
- obj_num_out  out  IDX_W  index for del_obj
- addr_vld  in  1  object unit allocation valid
- alloc_idx  in  IDX_W  allocated index, sampled with addr_vld
- obj_mem_full  in  1  no free slot
- mem_rd_en, mem_wr_en  out  1  one-cycle video-memory strobes
- mem_addr  out  IDX_W  object index for read/write
- mem_wr_data  out  OBJ_W  write word
- mem_rd_data  in  OBJ_W  read word, valid with mem_rd_vld
- mem_rd_vld  in  1  read data valid

## Operation
- States: IDLE, ALLOC, READ, WAIT_RD, XFORM, WRITE, DONE.
- IDLE: on go, latch all command inputs and enter the state selected by op. busy rises the next cycle. A go that arrives while busy is ignored.
- Create:
  - If obj_mem_full, go to DONE with err.
  - Otherwise enter ALLOC: pulse crt_obj, then wait for addr_vld.
  - On addr_vld, latch alloc_idx into lst_stored_obj and enter WRITE.
  - The write word is built from vin, colour and {6'b0, obj_type}.
- Delete: pulse del_obj with obj_num_out and del_all for one cycle, then DONE.
- Transform:
  - READ pulses mem_rd_en with mem_addr = obj_num_in.
  - WAIT_RD captures mem_rd_data on mem_rd_vld.
  - XFORM modifies vertex k in cycle k, for k = 0..NUM_VERTS-1. Only vertices with k ≤ stored type[1:0] are modified; the rest pass through unchanged.
  - WRITE pulses mem_wr_en with the same address.
- Vertex arithmetic, all signed at COORD_W:
  - Translate: (x+dx, y+dy).
  - Scale: shift left by code[1:0], or arithmetic right shift if code[2]=1.
  - Rot left: (-y, x). Rot right: (y, -x).
  - Reflect: code[0]=0 gives (x, -y); code[0]=1 gives (-x, y).
  - Without saturation, results wrap modulo 2^COORD_W.
- op 7 goes to DONE with err.
- DONE pulses done for one cycle, then returns to IDLE.
- Colour and type bytes are never altered by a transform.

## Timing
- Reset values: all outputs 0, state IDLE.
- Reset asserted mid-command aborts immediately. No strobe may be emitted after reset asserts.
- Delete: go at cycle 0; del_obj at cycle 1; done at cycle 2.
- Create: go at cycle 0; crt_obj at cycle 1; write one cycle after addr_vld; done the cycle after the write.
- Create, full: done and err at cycle 1.
- Transform: mem_rd_en at cycle 1; XFORM spans NUM_VERTS cycles after mem_rd_vld; write at capture+NUM_VERTS+1; done the cycle after.
- addr_vld and mem_rd_vld are sampled only in their wait states; pulses arriving elsewhere are ignored.
- No timeouts.

## Configuration
- GEO_SATURATE_EN defined:
  - Add, shift-left and negate results clamp to [-2^(COORD_W-1), 2^(COORD_W-1)-1].
  - Negating the minimum value yields the maximum value.
- GEO_SATURATE_EN undefined: two's-complement wrap; negating the minimum value yields the minimum value.

## Test plan
- Create, type 3, vin vertices (1,2),(3,4),(5,6),(7,8), colour 0xA5, alloc_idx 9 -> crt_obj at cycle 1; write to address 9 with type byte 0x03; lst_stored_obj = 9; done.
- Create with obj_mem_full=1 -> no crt_obj; done and err together at cycle 1.
- Translate object 4 (type 1, vertices (10,-5),(0,0)) by dx=3, dy=-2 -> written (13,-7),(3,-2); vertices 2 and 3 unchanged.
- Rot left of (100,-30) -> (30,100); reflect about y-axis of (-7,9) -> (7,9).
- x=32767 scaled up by 1 -> 32767 with GEO_SATURATE_EN, -2 without; -32768 negated -> 32767 with the macro, -32768 without.
- Reset asserted during WAIT_RD -> busy=0 on the next cycle; no mem_wr_en; next go is accepted normally.
